// File: rtl/lisnoc_xy_route_stage_if.sv
// Link bundle between an input link, the route stage and the switch allocator side.
// master = link driver / consumer side, slave = route stage.
interface lisnoc_xy_route_stage_if #(
  parameter int flit_width = 34,
  parameter int vchannels  = 1
);
  logic [flit_width-1:0]           in_flit;
  logic [vchannels-1:0]            in_valid;
  logic [vchannels-1:0]            in_ready;
  logic [flit_width*vchannels-1:0] out_flit;
  logic [5*vchannels-1:0]          out_dir;
  logic [vchannels-1:0]            out_valid;
  logic [vchannels-1:0]            out_ready;
  logic                            err;

  modport master (
    output in_flit, in_valid, out_ready,
    input  in_ready, out_flit, out_dir, out_valid, err
  );

  modport slave (
    input  in_flit, in_valid, out_ready,
    output in_ready, out_flit, out_dir, out_valid, err
  );
endinterface

// File: rtl/lisnoc_xy_route_stage.sv
// Per-input-port XY route computation with a 2-entry FIFO per virtual channel.
// Define LISNOC_XY_ROUTE_TORUS_EN for shortest-way routing over wrap-around links.
module lisnoc_xy_route_stage #(
  parameter int flit_type_width = 2,
  parameter int flit_data_width = 32,
  parameter int vchannels       = 1,
  parameter int xdim            = 2,
  parameter int ydim            = 2,
  parameter int x               = 0,
  parameter int y               = 0,
  parameter int ph_dest_width   = $clog2(xdim*ydim)
) (
  input  logic clk,
  input  logic rst_n,
  lisnoc_xy_route_stage_if.slave bus
);
  localparam int flit_width = flit_type_width + flit_data_width;

  localparam logic [1:0] TYPE_PAYLOAD = 2'b00;
  localparam logic [1:0] TYPE_HEADER  = 2'b01;
  localparam logic [1:0] TYPE_LAST    = 2'b10;
  localparam logic [1:0] TYPE_SINGLE  = 2'b11;

  localparam logic [4:0] DIR_N = 5'b00001;
  localparam logic [4:0] DIR_E = 5'b00010;
  localparam logic [4:0] DIR_S = 5'b00100;
  localparam logic [4:0] DIR_W = 5'b01000;
  localparam logic [4:0] DIR_L = 5'b10000;

  typedef enum logic {IDLE, PKT} state_t;

  function automatic logic [4:0] xy_route(input logic [ph_dest_width-1:0] d);
    int dv, xd, yd;
`ifdef LISNOC_XY_ROUTE_TORUS_EN
    int fx, fy;
`endif
    dv = int'(d);
    xd = dv % xdim;
    yd = dv / xdim;
    xy_route = DIR_L;
    if (dv < xdim*ydim) begin
`ifdef LISNOC_XY_ROUTE_TORUS_EN
      // fx/fy: hop count going the positive way; ties favour E and N
      fx = (xd - x + xdim) % xdim;
      fy = (yd - y + ydim) % ydim;
      if (fx != 0)      xy_route = (fx <= xdim - fx) ? DIR_E : DIR_W;
      else if (fy != 0) xy_route = (fy <= ydim - fy) ? DIR_N : DIR_S;
`else
      if (xd > x)      xy_route = DIR_E;
      else if (xd < x) xy_route = DIR_W;
      else if (yd > y) xy_route = DIR_N;
      else if (yd < y) xy_route = DIR_S;
`endif
    end
  endfunction

  logic [1:0]               in_type;
  logic [ph_dest_width-1:0] in_dest;
  logic                     dest_bad;
  logic [4:0]               hdr_dir;
  logic [vchannels-1:0]     err_set;
  logic                     err_q, err_d;

  assign in_type  = bus.in_flit[flit_width-1 -: 2];
  assign in_dest  = bus.in_flit[flit_data_width-1 -: ph_dest_width];
  assign dest_bad = int'(in_dest) >= xdim*ydim;
  assign hdr_dir  = xy_route(in_dest);

  for (genvar v = 0; v < vchannels; v++) begin : g_vc
    state_t                state_q, state_d;
    logic [4:0]            route_q, route_d;
    logic [flit_width-1:0] flit_mem_q [2];
    logic [4:0]            dir_mem_q  [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            count_q, count_d;
    logic                  rdy_q;
    logic                  accept, push, pop, err_v;
    logic [4:0]            push_dir;

    assign accept  = bus.in_valid[v] & rdy_q;
    assign pop     = (count_q != 2'd0) & bus.out_ready[v];
    assign count_d = count_q + {1'b0, push} - {1'b0, pop};

    always_comb begin
      state_d  = state_q;
      route_d  = route_q;
      push     = 1'b0;
      push_dir = route_q;
      err_v    = 1'b0;
      if (accept) begin
        case (in_type)
          TYPE_HEADER, TYPE_SINGLE: begin
            // a header inside a packet is flagged but still starts a new route
            push     = 1'b1;
            push_dir = hdr_dir;
            route_d  = hdr_dir;
            err_v    = dest_bad | (state_q == PKT);
            state_d  = (in_type == TYPE_HEADER) ? PKT : IDLE;
          end
          default: begin
            if (state_q == PKT) begin
              push = 1'b1;
              if (in_type == TYPE_LAST) state_d = IDLE;
            end else begin
              err_v = 1'b1;
            end
          end
        endcase
      end
    end

    assign err_set[v] = err_v;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q       <= IDLE;
        route_q       <= '0;
        wr_ptr_q      <= 1'b0;
        rd_ptr_q      <= 1'b0;
        count_q       <= 2'd0;
        rdy_q         <= 1'b1;
        flit_mem_q[0] <= '0;
        flit_mem_q[1] <= '0;
        dir_mem_q[0]  <= '0;
        dir_mem_q[1]  <= '0;
      end else begin
        state_q <= state_d;
        route_q <= route_d;
        count_q <= count_d;
        rdy_q   <= (count_d < 2'd2);
        if (push) begin
          flit_mem_q[wr_ptr_q] <= bus.in_flit;
          dir_mem_q[wr_ptr_q]  <= push_dir;
          wr_ptr_q             <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
    end

    assign bus.out_flit[v*flit_width +: flit_width] = flit_mem_q[rd_ptr_q];
    assign bus.out_dir[v*5 +: 5]                    = dir_mem_q[rd_ptr_q];
    assign bus.out_valid[v]                         = (count_q != 2'd0);
    assign bus.in_ready[v]                          = rdy_q;
  end

  assign err_d = err_q | (|err_set);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign bus.err = err_q;
endmodule

// File: tb/tb_lisnoc_xy_route_stage.sv
// Bench for lisnoc_xy_route_stage: 4x4 mesh node (1,1) with two VCs, plus a
// single-VC node (0,0) whose expected routes follow LISNOC_XY_ROUTE_TORUS_EN.
module tb_lisnoc_xy_route_stage;
  localparam int FW = 34;

  localparam logic [1:0] T_PAY = 2'b00, T_HDR = 2'b01, T_LST = 2'b10, T_SGL = 2'b11;
  localparam logic [4:0] D_N = 5'b00001, D_E = 5'b00010, D_S = 5'b00100,
                         D_W = 5'b01000, D_L = 5'b10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lisnoc_xy_route_stage_if #(.flit_width(FW), .vchannels(2)) bus0 ();
  lisnoc_xy_route_stage_if #(.flit_width(FW), .vchannels(1)) bus1 ();

  lisnoc_xy_route_stage #(
    .flit_type_width(2), .flit_data_width(32), .vchannels(2),
    .xdim(4), .ydim(4), .x(1), .y(1), .ph_dest_width(5)
  ) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  lisnoc_xy_route_stage #(
    .flit_type_width(2), .flit_data_width(32), .vchannels(1),
    .xdim(4), .ydim(4), .x(0), .y(0)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    logic [FW-1:0] flit;
    logic [4:0]    dir;
  } exp_t;

  typedef struct {
    int         vc;
    logic [1:0] typ;
    int         dest;
    logic [4:0] dir;
    bit         fwd;
    bit         err;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   err_exp = 1'b0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h required %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int qsize(input int vc);
    return (vc == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [FW-1:0] mkflit(input logic [1:0] typ, input int dest);
    logic [4:0]  d5;
    logic [26:0] pl;
    d5 = dest[4:0];
    pl = 27'($urandom);
    return {typ, d5, pl};
  endfunction

  task automatic check_outputs();
    exp_t h;
    for (int v = 0; v < 2; v++) begin
      check($sformatf("out_valid[%0d]", v), 64'(bus0.out_valid[v]), 64'(qsize(v) > 0));
      check($sformatf("in_ready[%0d]", v), 64'(bus0.in_ready[v]), 64'(qsize(v) < 2));
      if (qsize(v) > 0) begin
        h = (v == 0) ? q0[0] : q1[0];
        check($sformatf("out_flit[%0d]", v), 64'(bus0.out_flit[v*FW +: FW]), 64'(h.flit));
        check($sformatf("out_dir[%0d]", v), 64'(bus0.out_dir[v*5 +: 5]), 64'(h.dir));
      end
    end
    check("err", 64'(bus0.err), 64'(err_exp));
  endtask

  // One clock of the reference model: acceptance depends only on occupancy before the edge.
  task automatic tick(input int vc, input bit fwd, input logic [FW-1:0] f,
                      input logic [4:0] d, input bit errb, output bit acc);
    exp_t e;
    bit   p0, p1;
    e.flit = f;
    e.dir  = d;
    acc = 1'b0;
    if (vc >= 0) acc = (qsize(vc) < 2);
    p0 = (q0.size() > 0) && bus0.out_ready[0];
    p1 = (q1.size() > 0) && bus0.out_ready[1];
    @(posedge clk);
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (acc) begin
      if (errb) err_exp = 1'b1;
      if (fwd) begin
        if (vc == 0) q0.push_back(e);
        else         q1.push_back(e);
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(-1, 1'b0, '0, '0, 1'b0, acc);
  endtask

  task automatic send(input int vc, input logic [1:0] typ, input int dest,
                      input logic [4:0] d, input bit fwd, input bit errb);
    logic [FW-1:0] f;
    bit acc;
    int n;
    f = mkflit(typ, dest);
    bus0.in_flit      = f;
    bus0.in_valid     = '0;
    bus0.in_valid[vc] = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      tick(vc, fwd, f, d, errb, acc);
      n++;
    end
    if (!acc) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout vc%0d: got no acceptance required acceptance within 20 cycles", vc);
    end
    bus0.in_valid = '0;
  endtask

  // Asynchronous reset asserted between clock edges; state must clear without a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    bus0.in_valid = '0;
    #1;
    check("rst out_valid", 64'(bus0.out_valid), 64'h0);
    check("rst in_ready", 64'(bus0.in_ready), 64'h3);
    check("rst err", 64'(bus0.err), 64'h0);
    q0.delete();
    q1.delete();
    err_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [FW-1:0] f3;
  logic [FW-1:0] tf;
  logic [4:0]    tor_exp [3];
  int            tor_dst [3];
  bit            acc;
  int            n;

  initial begin
    bus0.in_flit = '0; bus0.in_valid = '0; bus0.out_ready = 2'b11;
    bus1.in_flit = '0; bus1.in_valid = '0; bus1.out_ready = 1'b1;

    // routes from (1,1) on a 4x4 grid
    tbl.push_back('{0, T_HDR, 7,  D_E, 1'b1, 1'b0});
    tbl.push_back('{0, T_PAY, 0,  D_E, 1'b1, 1'b0});
    tbl.push_back('{0, T_LST, 0,  D_E, 1'b1, 1'b0});
    tbl.push_back('{0, T_SGL, 13, D_N, 1'b1, 1'b0});
    tbl.push_back('{0, T_SGL, 1,  D_S, 1'b1, 1'b0});
    tbl.push_back('{0, T_SGL, 4,  D_W, 1'b1, 1'b0});
    tbl.push_back('{0, T_SGL, 5,  D_L, 1'b1, 1'b0});
    tbl.push_back('{0, T_HDR, 7,  D_E, 1'b1, 1'b0});
    tbl.push_back('{1, T_HDR, 13, D_N, 1'b1, 1'b0});
    tbl.push_back('{0, T_PAY, 0,  D_E, 1'b1, 1'b0});
    tbl.push_back('{1, T_PAY, 0,  D_N, 1'b1, 1'b0});
    tbl.push_back('{1, T_PAY, 0,  D_N, 1'b1, 1'b0});
    tbl.push_back('{0, T_LST, 0,  D_E, 1'b1, 1'b0});
    tbl.push_back('{1, T_LST, 0,  D_N, 1'b1, 1'b0});

    #12;
    check("init out_valid", 64'(bus0.out_valid), 64'h0);
    check("init in_ready", 64'(bus0.in_ready), 64'h3);
    check("init out_flit", 64'(bus0.out_flit[FW-1:0]), 64'h0);
    check("init out_dir", 64'(bus0.out_dir), 64'h0);
    check("init err", 64'(bus0.err), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef LISNOC_XY_ROUTE_TORUS_EN
    tor_exp[0] = D_W; tor_exp[1] = D_E; tor_exp[2] = D_S;
`else
    tor_exp[0] = D_E; tor_exp[1] = D_E; tor_exp[2] = D_N;
`endif
    tor_dst[0] = 3; tor_dst[1] = 2; tor_dst[2] = 12;
    for (int i = 0; i < 3; i++) begin
      tf = {T_SGL, 4'(tor_dst[i]), 28'($urandom)};
      bus1.in_flit  = tf;
      bus1.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("node00 valid dest%0d", tor_dst[i]), 64'(bus1.out_valid), 64'h1);
      check($sformatf("node00 dir dest%0d", tor_dst[i]), 64'(bus1.out_dir), 64'(tor_exp[i]));
      check($sformatf("node00 flit dest%0d", tor_dst[i]), 64'(bus1.out_flit), 64'(tf));
    end
    bus1.in_valid = 1'b0;
    @(negedge clk);
    check("node00 err", 64'(bus1.err), 64'h0);

    foreach (tbl[i]) send(tbl[i].vc, tbl[i].typ, tbl[i].dest, tbl[i].dir, tbl[i].fwd, tbl[i].err);
    idle(3);

    // backpressure: two accepted, third stalls until a pop frees a slot
    bus0.out_ready = 2'b10;
    send(0, T_HDR, 7, D_E, 1'b1, 1'b0);
    send(0, T_PAY, 0, D_E, 1'b1, 1'b0);
    f3 = mkflit(T_PAY, 0);
    bus0.in_flit = f3;
    bus0.in_valid = 2'b01;
    for (int i = 0; i < 3; i++) tick(0, 1'b1, f3, D_E, 1'b0, acc);
    bus0.out_ready = 2'b11;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 10) begin
      tick(0, 1'b1, f3, D_E, 1'b0, acc);
      n++;
    end
    check("stall third accepted", 64'(acc), 64'h1);
    bus0.in_valid = '0;
    send(0, T_LST, 0, D_E, 1'b1, 1'b0);
    idle(3);

    // protocol errors and mid-packet reset
    send(0, T_PAY, 0, D_E, 1'b0, 1'b1);
    idle(2);
    bus0.out_ready = 2'b10;
    send(0, T_HDR, 7, D_E, 1'b1, 1'b0);
    idle(1);
    do_reset();
    bus0.out_ready = 2'b11;
    idle(1);
    send(0, T_PAY, 0, D_E, 1'b0, 1'b1);
    idle(2);
    do_reset();
    idle(1);
    send(1, T_SGL, 16, D_L, 1'b1, 1'b1);
    idle(2);
    do_reset();
    idle(1);
    send(0, T_HDR, 7,  D_E, 1'b1, 1'b0);
    send(0, T_HDR, 13, D_N, 1'b1, 1'b1);
    send(0, T_PAY, 0,  D_N, 1'b1, 1'b0);
    send(0, T_LST, 0,  D_N, 1'b1, 1'b0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/lisnoc_xy_route_stage.md
Name: lisnoc_xy_route_stage

Overview:
Per-input-port route-computation and buffering stage for the next-generation 2D grid router.
- Replaces the elaboration-time lookup table with run-time XY dimension-order computation from the header destination field.
- Holds the computed route per virtual channel for the whole wormhole packet.
- Provides a 2-entry registered FIFO per virtual channel.
- Sits between a link input (neighbour or local) and the router's switch allocator; one instance per input port.

Parameters:
flit_type_width, 2, flit type field width (MSBs of flit)
flit_data_width, 32, flit data field width
vchannels, 1, number of virtual channels
xdim, 2, grid X dimension
ydim, 2, grid Y dimension
x, 0, X coordinate of this router
y, 0, Y coordinate of this router
ph_dest_width, $clog2(xdim*ydim), destination field width in header (MSBs of data field)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
in_flit  input  flit_width  incoming flit, shared across VCs
in_valid  input  vchannels  per-VC valid (at most one set per cycle)
in_ready  output  vchannels  per-VC ready
out_flit  output  flit_width*vchannels  head-of-FIFO flit per VC (VC0 at LSBs)
out_dir  output  5*vchannels  one-hot direction per VC: N=00001, E=00010, S=00100, W=01000, L=10000
out_valid  output  vchannels  per-VC head valid
out_ready  input  vchannels  per-VC consumer ready
err  output  1  sticky protocol/destination error

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all FIFOs empty; out_valid=0; out_flit=0; out_dir=0; err=0; all VCs in IDLE; in_ready=1 on all VCs.
- Flit type (flit[flit_width-1 -: 2]) encodings:
  - 01 = HEADER
  - 00 = PAYLOAD
  - 10 = LAST
  - 11 = SINGLE
- Destination: dest = flit[flit_data_width-1 -: ph_dest_width]; xd = dest % xdim; yd = dest / xdim.
- Route, X first:
  - xd>x → E; xd<x → W.
  - Otherwise yd>y → N; yd<y → S.
  - Otherwise L.
- Per-VC FSM:
  - IDLE:
    - HEADER: compute route, latch it in the VC route register, enqueue flit+route, go to PKT.
    - SINGLE: compute route, enqueue, stay in IDLE.
    - PAYLOAD/LAST: accept (handshake completes), drop, set err, stay in IDLE.
  - PKT:
    - PAYLOAD: enqueue with the latched route.
    - LAST: enqueue with the latched route, go to IDLE.
    - HEADER/SINGLE: set err, treat as a new header (recompute route, relatch); SINGLE goes to IDLE.
- Invalid destination (dest >= xdim*ydim): route L, set err; the flit is still forwarded.
- Handshake:
  - Input transfer when in_valid[v] && in_ready[v].
  - Output transfer when out_valid[v] && out_ready[v].
  - out_flit/out_dir stay stable while out_valid=1 and out_ready=0.
- FIFO:
  - Depth 2 per VC; in_ready[v] = (count[v] < 2), registered, independent of out_ready.
  - Simultaneous push and pop when count=1: count stays 1, order preserved.
  - Pop from empty and push to full never occur.
- Latency: a flit accepted in cycle n is presented on out_* in cycle n+1 (zero-bubble when out_ready=1). Full throughput is 1 flit/cycle per VC.
- VCs are independent: interleaved packets on different VCs keep separate route registers and FSMs.
- Reset mid-packet clears FSMs and FIFOs immediately (asynchronous); flits in flight are discarded.
- err clears only on reset.

Optional Feature:
LISNOC_XY_ROUTE_TORUS_EN
- Defined: wrap-around links are assumed. Per dimension, take the shorter direction modulo the dimension; on equal distance choose E (X) or N (Y). X is still resolved before Y.
- Undefined: plain mesh routing as above; no wrap-around direction is ever produced.

Test Plan:
1. Mesh, xdim=ydim=4, x=1, y=1: HEADER dest=7, PAYLOAD, LAST on VC0 with out_ready=1 → three flits appear one cycle after acceptance, all with out_dir=00010 (E); FSM returns to IDLE.
2. Same node, SINGLE flits dest=13, 1, 4, 5 → out_dir=00001 (N), 00100 (S), 01000 (W), 10000 (L); err stays 0.
3. TORUS_EN, 4x4, x=0, y=0: dest=3 → W; dest=2 → E (tie); dest=12 → S.
   Without the macro, dest=3 → E and dest=12 → N.
4. out_ready=0, push 3 flits on VC0 → first two accepted, in_ready[0]=0 after the second. Raise out_ready → flits emerge in order, in_ready reasserts the cycle after the first pop.
5. vchannels=2: HEADER dest=7 on VC0, HEADER dest=13 on VC1, then interleave payloads and LASTs → VC0 flits all E, VC1 flits all N.
6. PAYLOAD in IDLE → accepted, not output, err=1. SINGLE dest=16 (4x4) → out_dir=L, err=1. Assert rst low mid-packet → out_valid=0, in_ready=1, err=0.
